// File: rtl/mux_sweep_pkg.sv
// Shared definitions for the 4x1 MUX sweep controller.
//   state_t  : controller states (IDLE, SETTLE, DONE)
//   SEL_W    : width of the MUX select drive
//   NUM_IN   : number of MUX data inputs (truth-table word width)
//   LAST_SEL : final select value of a sweep
package mux_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam int              SEL_W    = 2;
    localparam int              NUM_IN   = 4;
    localparam logic [SEL_W-1:0] LAST_SEL = 2'd3;

endpackage : mux_sweep_pkg

// File: rtl/mux_sweep_ctrl_dwell_timer.sv
// Dwell timer for the MUX sweep controller.
// Counts enabled cycles from 0 up to DWELL-1, then wraps to 0 on its own.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset (count -> 0)
//   clr   : synchronous clear, dominates enable
//   en    : advance the count this cycle
//   tc    : terminal count, high while count == DWELL-1
module dwell_timer #(
    parameter int DWELL   = 2,
    parameter int DWELL_W = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam logic [DWELL_W-1:0] TC_VAL = DWELL_W'(DWELL - 1);

    logic [DWELL_W-1:0] count;

    assign tc = (count == TC_VAL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            // Wrap at terminal count so each select gets a fresh dwell.
            count <= tc ? '0 : count + 1'b1;
        end
    end

endmodule : dwell_timer

// File: rtl/mux_sweep_ctrl.sv
// Upstream driver and result collector for the 4x1 MUX stage.
// On an accepted start it drives a truth-table word onto the MUX data
// inputs, steps the select through 0..3 holding each for DWELL cycles,
// samples the MUX output at the end of each dwell and reports the
// captured response plus a match flag.
//   clk     : system clock, rising edge
//   rst_n   : asynchronous active-low reset
//   start   : sweep request, only looked at in IDLE
//   func_in : truth-table word, latched on an accepted start
//   f_in    : MUX output fed back from the MUX stage
//   s_out   : MUX select drive
//   i_out   : MUX data-input drive
//   busy    : sweep in progress
//   done    : one-cycle completion pulse
//   result  : captured response, bit k sampled while s_out == k
//   match   : result == i_out, valid from done until the next start
module mux_sweep_ctrl
    import mux_sweep_pkg::*;
#(
    parameter int DWELL   = 2,
    parameter int DWELL_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [NUM_IN-1:0] func_in,
    input  logic              f_in,
    output logic [SEL_W-1:0]  s_out,
    output logic [NUM_IN-1:0] i_out,
    output logic              busy,
    output logic              done,
    output logic [NUM_IN-1:0] result,
    output logic              match
);

    state_t            state;
    logic              tc;
    logic              tmr_clr;
    logic              tmr_en;
    logic [NUM_IN-1:0] result_next;

    // The timer only runs in SETTLE; holding it clear elsewhere means it
    // is already at 0 on the first SETTLE cycle after a start.
    assign tmr_clr = (state != SETTLE);
    assign tmr_en  = (state == SETTLE);

    dwell_timer #(
        .DWELL   (DWELL),
        .DWELL_W (DWELL_W)
    ) u_dwell_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (tmr_clr),
        .en    (tmr_en),
        .tc    (tc)
    );

    // Result including the bit being sampled on this edge, so the final
    // match compare sees all four bits.
    always_comb begin
        result_next        = result;
        result_next[s_out] = f_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            s_out  <= '0;
            i_out  <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            match  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    s_out <= '0;
                    if (start) begin
                        i_out  <= func_in;
                        result <= '0;
                        match  <= 1'b0;
                        busy   <= 1'b1;
                        state  <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (tc) begin
                        result <= result_next;
                        if (s_out == LAST_SEL) begin
                            match <= (result_next == i_out);
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            s_out <= s_out + 1'b1;
                        end
                    end
                end
                DONE: begin
                    // Select returns to 0 here, never by wrapping in SETTLE.
                    done  <= 1'b0;
                    s_out <= '0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule : mux_sweep_ctrl

// File: tb/tb_mux_sweep_ctrl.sv
module tb_mux_sweep_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       fault;

    // DWELL=2 instance
    logic       start;
    logic [3:0] func_in;
    logic       f_in;
    logic [1:0] s_out;
    logic [3:0] i_out;
    logic       busy, done, match;
    logic [3:0] result;

    // DWELL=1 instance
    logic       start1;
    logic [3:0] func1;
    logic       f1;
    logic [1:0] s1;
    logic [3:0] i1;
    logic       busy1, done1, match1;
    logic [3:0] result1;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    int base;

    always #5 clk = ~clk;

    // 4x1 MUX in the loop; fault forces its output low.
    assign f_in = fault ? 1'b0 : i_out[s_out];
    assign f1   = i1[s1];

    always @(posedge clk) if (done) done_cnt <= done_cnt + 1;

    mux_sweep_ctrl #(.DWELL(2), .DWELL_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .func_in(func_in), .f_in(f_in),
        .s_out(s_out), .i_out(i_out), .busy(busy), .done(done),
        .result(result), .match(match)
    );

    mux_sweep_ctrl #(.DWELL(1), .DWELL_W(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .func_in(func1), .f_in(f1),
        .s_out(s1), .i_out(i1), .busy(busy1), .done(done1),
        .result(result1), .match(match1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Start a sweep on dut and return in the done cycle (after edge E0+8).
    task automatic sweep(input logic [3:0] f);
        func_in = f;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        repeat (8) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1. Reset with random inputs
        rst_n   = 1'b0;
        fault   = 1'($urandom);
        start   = 1'($urandom);
        func_in = 4'($urandom);
        start1  = 1'($urandom);
        func1   = 4'($urandom);
        repeat (3) tick();
        check("rst_s",      32'(s_out),  0);
        check("rst_i",      32'(i_out),  0);
        check("rst_busy",   32'(busy),   0);
        check("rst_done",   32'(done),   0);
        check("rst_result", 32'(result), 0);
        check("rst_match",  32'(match),  0);
        check("rst1_s",     32'(s1),     0);
        check("rst1_busy",  32'(busy1),  0);
        rst_n  = 1'b1;
        start  = 1'b0;
        start1 = 1'b0;
        fault  = 1'b0;
        repeat (3) tick();
        check("idle_busy", 32'(busy),  0);
        check("idle_done", 32'(done),  0);
        check("idle_s",    32'(s_out), 0);
        check("idle_i",    32'(i_out), 0);

        // 2. Normal sweep 1010
        func_in = 4'b1010;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        check("sw_i", 32'(i_out), 32'hA);
        for (int k = 0; k < 8; k++) begin
            check("sw_busy", 32'(busy),  1);
            check("sw_sel",  32'(s_out), 32'(k / 2));
            check("sw_done", 32'(done),  0);
            tick();
        end
        check("sw_done_pulse", 32'(done),   1);
        check("sw_busy_end",   32'(busy),   0);
        check("sw_result",     32'(result), 32'hA);
        check("sw_match",      32'(match),  1);
        check("sw_sel_done",   32'(s_out),  3);
        tick();
        check("sw_done_clr",   32'(done),   0);
        check("sw_sel_idle",   32'(s_out),  0);
        check("sw_result_hold",32'(result), 32'hA);
        check("sw_match_hold", 32'(match),  1);

        // 3. Fault then restored loop
        fault = 1'b1;
        sweep(4'b0110);
        check("flt_done",   32'(done),   1);
        check("flt_result", 32'(result), 0);
        check("flt_match",  32'(match),  0);
        tick();
        fault = 1'b0;
        sweep(4'b0001);
        check("rec_done",   32'(done),   1);
        check("rec_result", 32'(result), 1);
        check("rec_match",  32'(match),  1);
        tick();

        // 4. Start while busy is ignored
        base    = done_cnt;
        func_in = 4'b1100;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        tick();
        tick();
        func_in = 4'b0011;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        check("ign_i",    32'(i_out), 32'hC);
        check("ign_busy", 32'(busy),  1);
        repeat (4) tick();
        check("ign_no_early_done", 32'(done), 0);
        tick();
        check("ign_done",   32'(done),   1);
        check("ign_result", 32'(result), 32'hC);
        check("ign_match",  32'(match),  1);
        tick();
        tick();
        check("ign_one_done", 32'(done_cnt - base), 1);
        check("ign_idle",     32'(busy),            0);

        // 5. Reset mid-sweep
        base    = done_cnt;
        func_in = 4'b0110;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        repeat (4) tick();
        check("mid_sel2", 32'(s_out), 2);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_s",      32'(s_out),  0);
        check("mid_i",      32'(i_out),  0);
        check("mid_busy",   32'(busy),   0);
        check("mid_done",   32'(done),   0);
        check("mid_result", 32'(result), 0);
        check("mid_match",  32'(match),  0);
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (6) tick();
        check("mid_no_done", 32'(done_cnt - base), 0);
        check("mid_idle",    32'(busy),            0);
        sweep(4'b1111);
        check("post_done",   32'(done),   1);
        check("post_result", 32'(result), 32'hF);
        check("post_match",  32'(match),  1);
        tick();

        // 6. DWELL=1 with start held high
        func1  = 4'b0101;
        start1 = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) begin
            check("d1_sel",  32'(s1),    32'(k));
            check("d1_busy", 32'(busy1), 1);
            check("d1_done", 32'(done1), 0);
            tick();
        end
        check("d1_done_pulse", 32'(done1),   1);
        check("d1_result",     32'(result1), 32'h5);
        check("d1_match",      32'(match1),  1);
        check("d1_sel_done",   32'(s1),      3);
        tick();
        check("d1_idle_busy", 32'(busy1), 0);
        check("d1_idle_sel",  32'(s1),    0);
        check("d1_idle_done", 32'(done1), 0);
        tick();
        check("d1_restart", 32'(busy1), 1);
        repeat (3) tick();
        check("d1_no_early", 32'(done1), 0);
        tick();
        check("d1_done2",   32'(done1),   1);
        check("d1_result2", 32'(result1), 32'h5);
        start1 = 1'b0;
        tick();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_mux_sweep_ctrl
